// File: rtl/hilbert_fir_filter_if.sv
// Signal bundle between the Hilbert FIR stage, its coefficient-setup block and the sample source/sink.
// The filter uses the slave view; whoever drives samples and coefficients uses the master view.
interface hilbert_fir_filter_if #(
   parameter int DATA_WIDTH = 18,
   parameter int OUT_WIDTH  = 41
);
   logic                         enable;
   logic                         coeffEnable;
   logic                         coeffSetFlag;
   logic signed [DATA_WIDTH-1:0] coefficientIn;
   logic signed [DATA_WIDTH-1:0] dataIn;
   logic                         dataInValid;
   logic                         coeffReady;
   logic signed [DATA_WIDTH-1:0] realOut;
   logic signed [OUT_WIDTH-1:0]  imagOut;
   logic                         dataOutValid;

   modport master (
      output enable, coeffSetFlag, coefficientIn, dataIn, dataInValid,
      input  coeffEnable, coeffReady, realOut, imagOut, dataOutValid
   );

   modport slave (
      input  enable, coeffSetFlag, coefficientIn, dataIn, dataInValid,
      output coeffEnable, coeffReady, realOut, imagOut, dataOutValid
   );
endinterface

// File: rtl/hilbert_fir_filter.sv
// Hilbert transform FIR stage: loads its tap bank from the serial coefficient stream,
// then produces an I/Q pair (group-delayed input, Hilbert output) three cycles after each valid sample.
module hilbert_fir_filter #(
   parameter int LENGTH     = 27,
   parameter int DATA_WIDTH = 18,
   parameter int OUT_WIDTH  = 41
) (
   input logic                 clock,
   input logic                 resetN,
   hilbert_fir_filter_if.slave bus
);
   localparam int MID         = (LENGTH - 1) / 2;
   localparam int PROD_WIDTH  = 2 * DATA_WIDTH;
   localparam int COUNT_WIDTH = $clog2(LENGTH + 1);
   localparam logic [COUNT_WIDTH-1:0] LAST_COUNT = COUNT_WIDTH'(LENGTH);

   typedef enum logic [1:0] {IDLE, LOAD, FILTER} state_t;

   state_t                       state;
   state_t                       nextState;
   logic [COUNT_WIDTH-1:0]       loadCount;
   logic                         loadPrimed;
   logic signed [DATA_WIDTH-1:0] bank      [LENGTH];
   logic signed [DATA_WIDTH-1:0] delayLine [LENGTH];
   logic signed [PROD_WIDTH-1:0] products  [LENGTH];
   logic signed [DATA_WIDTH-1:0] realStage;
   logic                         validStage1;
   logic                         validStage2;
   logic signed [OUT_WIDTH-1:0]  productSum;
   logic                         filterNext;
   logic                         filterHold;

   assign filterNext = (nextState == FILTER);
   assign filterHold = (state == FILTER) && filterNext;

   always_comb begin
      nextState = state;
      case (state)
         IDLE: begin
            if (bus.enable) nextState = LOAD;
         end
         LOAD: begin
            if (!bus.enable)
               nextState = IDLE;
            else if (loadPrimed && (bus.coeffSetFlag || loadCount == LAST_COUNT))
               nextState = FILTER;
         end
         FILTER: begin
            if (!bus.enable) nextState = IDLE;
         end
         default: nextState = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         state           <= IDLE;
         bus.coeffEnable <= 1'b0;
         bus.coeffReady  <= 1'b0;
      end else begin
         state           <= nextState;
         bus.coeffEnable <= (nextState == LOAD);
         bus.coeffReady  <= filterNext;
      end
   end

   // The first LOAD edge only primes the capture: the setup block has not produced coefficient 0 yet.
   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         loadCount  <= '0;
         loadPrimed <= 1'b0;
         for (int k = 0; k < LENGTH; k++) bank[k] <= '0;
      end else if (state == LOAD && bus.enable) begin
         if (!loadPrimed) begin
            loadPrimed <= 1'b1;
         end else if (loadCount < LAST_COUNT) begin
            for (int k = 0; k < LENGTH; k++) begin
               if (loadCount == COUNT_WIDTH'(k)) bank[k] <= bus.coefficientIn;
            end
            loadCount <= loadCount + 1'b1;
         end
      end else begin
         loadCount  <= '0;
         loadPrimed <= 1'b0;
      end
   end

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         validStage1 <= 1'b0;
         for (int k = 0; k < LENGTH; k++) delayLine[k] <= '0;
      end else if (!filterNext) begin
         validStage1 <= 1'b0;
         for (int k = 0; k < LENGTH; k++) delayLine[k] <= '0;
      end else begin
         validStage1 <= filterHold && bus.dataInValid;
         if (filterHold && bus.dataInValid) begin
            delayLine[0] <= bus.dataIn;
            for (int k = 1; k < LENGTH; k++) delayLine[k] <= delayLine[k-1];
         end
      end
   end

   // The centre tap is captured with the products so realOut lines up with imagOut.
   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         validStage2 <= 1'b0;
         realStage   <= '0;
         for (int k = 0; k < LENGTH; k++) products[k] <= '0;
      end else begin
         validStage2 <= validStage1 && filterNext;
         if (validStage1 && filterNext) begin
            realStage <= delayLine[MID];
            for (int k = 0; k < LENGTH; k++)
               products[k] <= PROD_WIDTH'(bank[k]) * PROD_WIDTH'(delayLine[k]);
         end
      end
   end

   always_comb begin
      productSum = '0;
      for (int k = 0; k < LENGTH; k++)
         productSum = productSum + {{(OUT_WIDTH-PROD_WIDTH){products[k][PROD_WIDTH-1]}}, products[k]};
   end

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         bus.dataOutValid <= 1'b0;
         bus.imagOut      <= '0;
         bus.realOut      <= '0;
      end else begin
         bus.dataOutValid <= validStage2 && filterNext;
         if (validStage2 && filterNext) begin
            bus.imagOut <= productSum;
            bus.realOut <= realStage;
         end
      end
   end
endmodule

// File: tb/tb_hilbert_fir_filter.sv
// Bench for hilbert_fir_filter: emulates the coefficient-setup block and checks every cycle
// against a convolution model of the accepted sample history, plus literal impulse/constant results.
module tb_hilbert_fir_filter;
   localparam int LENGTH     = 27;
   localparam int DATA_WIDTH = 18;
   localparam int OUT_WIDTH  = 41;
   localparam int MID        = 13;

   logic clock;
   logic resetN;

   hilbert_fir_filter_if #(.DATA_WIDTH(DATA_WIDTH), .OUT_WIDTH(OUT_WIDTH)) bus ();

   hilbert_fir_filter #(
      .LENGTH(LENGTH), .DATA_WIDTH(DATA_WIDTH), .OUT_WIDTH(OUT_WIDTH)
   ) dut (
      .clock (clock),
      .resetN(resetN),
      .bus   (bus)
   );

   int     checkCount = 0;
   int     passCount  = 0;
   longint edgeCount  = 0;
   longint expImag [longint];
   longint expReal [longint];
   longint hist [$];
   bit     modelFilter;
   longint obsImag [$];
   longint obsReal [$];
   longint obsEdge [$];
   longint lastImag;
   longint lastReal;
   bit     ceSampled;
   int     setupIndex;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Antisymmetric Hilbert taps: zero at even distances from the centre, negative before it.
   function automatic longint coefOf(input int k);
      int     d;
      int     ad;
      longint mag;
      d  = MID - k;
      ad = (d < 0) ? -d : d;
      case (ad)
         1:       mag = 80000;
         3:       mag = 25000;
         5:       mag = 14000;
         7:       mag = 8800;
         9:       mag = 5600;
         11:      mag = 1582;
         13:      mag = 775;
         default: mag = 0;
      endcase
      return (d > 0) ? -mag : mag;
   endfunction

   task automatic checkOutput(input string name, input longint actual, input longint expected);
      checkCount++;
      if (actual == expected) passCount++;
      else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
   endtask

   // Setup block: registered, one coefficient per cycle once it has seen coeffEnable high.
   always @(negedge clock) ceSampled = bus.coeffEnable;

   always @(posedge clock) begin
      #1;
      if (!ceSampled) begin
         setupIndex        = 0;
         bus.coefficientIn = '0;
         bus.coeffSetFlag  = 1'b0;
      end else if (setupIndex < LENGTH) begin
         bus.coefficientIn = DATA_WIDTH'(coefOf(setupIndex));
         bus.coeffSetFlag  = (setupIndex == LENGTH - 1);
         setupIndex++;
      end else begin
         bus.coefficientIn = '0;
         bus.coeffSetFlag  = 1'b0;
      end
   end

   // Reference: each accepted sample yields sum h[k]*x[n-k] and x[n-MID], visible two edges later.
   always @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         modelFilter = 1'b0;
         hist.delete();
         expImag.delete();
         expReal.delete();
      end else begin
         edgeCount++;
         if (modelFilter && bus.enable && bus.dataInValid) begin
            longint acc;
            acc = 0;
            hist.push_front(longint'(bus.dataIn));
            if (hist.size() > LENGTH) void'(hist.pop_back());
            for (int k = 0; k < hist.size(); k++) acc += coefOf(k) * hist[k];
            expImag[edgeCount + 2] = acc;
            expReal[edgeCount + 2] = (hist.size() > MID) ? hist[MID] : 0;
         end
         if (!bus.enable) begin
            modelFilter = 1'b0;
            hist.delete();
            expImag.delete();
            expReal.delete();
         end else if (bus.coeffSetFlag) begin
            modelFilter = 1'b1;
         end
      end
   end

   always @(negedge clock) begin
      if (!resetN) begin
         lastImag = 0;
         lastReal = 0;
      end else begin
         bit expValid;
         expValid = expImag.exists(edgeCount);
         checkOutput("dataOutValid", longint'(bus.dataOutValid), longint'(expValid));
         if (expValid) begin
            lastImag = expImag[edgeCount];
            lastReal = expReal[edgeCount];
         end
         checkOutput("imagOut", longint'(bus.imagOut), lastImag);
         checkOutput("realOut", longint'(bus.realOut), lastReal);
         if (bus.dataOutValid) begin
            obsImag.push_back(longint'(bus.imagOut));
            obsReal.push_back(longint'(bus.realOut));
            obsEdge.push_back(edgeCount);
         end
      end
   end

   function automatic longint pickImag(input int base, input int idx);
      return (base + idx < obsImag.size()) ? obsImag[base + idx] : longint'(32'h0BADBEEF);
   endfunction

   function automatic longint pickReal(input int base, input int idx);
      return (base + idx < obsReal.size()) ? obsReal[base + idx] : longint'(32'h0BADBEEF);
   endfunction

   function automatic longint pickEdge(input int base, input int idx);
      return (base + idx < obsEdge.size()) ? obsEdge[base + idx] : longint'(-1000);
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic applyStimulus(input int value, input int spacing);
      bus.dataIn      = DATA_WIDTH'(value);
      bus.dataInValid = 1'b1;
      tick();
      bus.dataInValid = 1'b0;
      repeat (spacing - 1) tick();
   endtask

   task automatic loadCoefficients(input bit holdValid);
      int highCount;
      int flagCycle;
      int readyCycle;
      int base;
      highCount  = 0;
      flagCycle  = -100;
      readyCycle = -1;
      base       = obsImag.size();
      bus.enable = 1'b1;
      for (int i = 0; i < 200 && readyCycle < 0; i++) begin
         if (holdValid) begin
            bus.dataInValid = 1'b1;
            bus.dataIn      = DATA_WIDTH'($urandom);
         end
         @(posedge clock);
         #2;
         if (bus.coeffEnable)  highCount++;
         if (bus.coeffSetFlag) flagCycle = i;
         if (bus.coeffReady)   readyCycle = i;
      end
      checkOutput("coeffEnable cycles", highCount, 28);
      checkOutput("coeffReady after flag", readyCycle - flagCycle, 1);
      checkOutput("outputs during load", obsImag.size() - base, 0);
   endtask

   task automatic disableBlock();
      bus.enable      = 1'b0;
      bus.dataInValid = 1'b0;
      tick();
      checkOutput("coeffEnable after disable", longint'(bus.coeffEnable), 0);
      checkOutput("coeffReady after disable", longint'(bus.coeffReady), 0);
      tick();
   endtask

   task automatic randomRun(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         bus.dataInValid = ($urandom_range(0, 3) != 0);
         bus.dataIn      = DATA_WIDTH'($urandom);
         tick();
      end
      bus.dataInValid = 1'b0;
   endtask

   task automatic impulseTest(input int spacing);
      int     base;
      longint inputEdge;
      base      = obsImag.size();
      inputEdge = edgeCount;
      applyStimulus(1000, spacing);
      for (int i = 1; i < 40; i++) applyStimulus(0, spacing);
      repeat (6) tick();
      checkOutput("impulse output count", obsImag.size() - base, 40);
      checkOutput("impulse imag[0]", pickImag(base, 0), -775000);
      checkOutput("impulse imag[1]", pickImag(base, 1), 0);
      checkOutput("impulse imag[2]", pickImag(base, 2), -1582000);
      checkOutput("impulse imag[12]", pickImag(base, 12), -80000000);
      checkOutput("impulse imag[26]", pickImag(base, 26), 775000);
      checkOutput("impulse real[12]", pickReal(base, 12), 0);
      checkOutput("impulse real[13]", pickReal(base, 13), 1000);
      checkOutput("impulse latency", pickEdge(base, 0) - inputEdge, 3);
      checkOutput("strobe spacing", pickEdge(base, 1) - pickEdge(base, 0), spacing);
   endtask

   task automatic constantTest();
      int base;
      base = obsImag.size();
      for (int i = 0; i < 30; i++) applyStimulus(100, 1);
      repeat (6) tick();
      checkOutput("constant output count", obsImag.size() - base, 30);
      checkOutput("constant imag[0]", pickImag(base, 0), -77500);
      checkOutput("constant imag[29]", pickImag(base, 29), 0);
      checkOutput("constant real[29]", pickReal(base, 29), 100);
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: time limit reached, got no finish, expected finish");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      resetN          = 1'b0;
      bus.enable      = 1'b0;
      bus.dataIn      = '0;
      bus.dataInValid = 1'b0;
      #12;
      checkOutput("reset realOut", longint'(bus.realOut), 0);
      checkOutput("reset imagOut", longint'(bus.imagOut), 0);
      checkOutput("reset dataOutValid", longint'(bus.dataOutValid), 0);
      checkOutput("reset coeffEnable", longint'(bus.coeffEnable), 0);
      checkOutput("reset coeffReady", longint'(bus.coeffReady), 0);
      tick();
      resetN = 1'b1;
      tick();

      loadCoefficients(1'b0);
      impulseTest(1);

      disableBlock();
      loadCoefficients(1'b0);
      impulseTest(3);

      disableBlock();
      loadCoefficients(1'b0);
      constantTest();

      disableBlock();
      loadCoefficients(1'b1);
      randomRun(300);
      repeat (6) tick();

      disableBlock();
      bus.enable = 1'b1;
      repeat (10) tick();
      checkOutput("coeffEnable mid-load", longint'(bus.coeffEnable), 1);
      bus.enable = 1'b0;
      tick();
      checkOutput("coeffEnable after load abort", longint'(bus.coeffEnable), 0);
      checkOutput("coeffReady after load abort", longint'(bus.coeffReady), 0);
      tick();
      loadCoefficients(1'b0);
      randomRun(200);

      @(posedge clock);
      #3;
      resetN = 1'b0;
      #1;
      checkOutput("async reset realOut", longint'(bus.realOut), 0);
      checkOutput("async reset imagOut", longint'(bus.imagOut), 0);
      checkOutput("async reset dataOutValid", longint'(bus.dataOutValid), 0);
      checkOutput("async reset coeffEnable", longint'(bus.coeffEnable), 0);
      checkOutput("async reset coeffReady", longint'(bus.coeffReady), 0);
      bus.enable      = 1'b0;
      bus.dataInValid = 1'b0;
      #15;
      resetN = 1'b1;
      tick();
      loadCoefficients(1'b0);
      randomRun(100);
      repeat (6) tick();

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end
endmodule
